flag_handshake_sender: RTL and testbench
========================================

# flag_handshake_sender

Transmit end of a toggle-encoded request/acknowledge pulse crossing, living entirely in the clkA domain. Accepts one-cycle event pulses, queues them in a saturating counter, and releases them one at a time as toggles on a request line. Each release waits for the far domain's acknowledge toggle to return through an internal synchronizer. This gives lossless, back-pressured event transfer where a bare toggle crossing would merge closely spaced pulses.

## Interface
- SYNC_STAGES, 2: flops in the acknowledge synchronizer (≥2).
- CNT_W, 4: pending-counter width; maximum queued events is 2^CNT_W−1.
- TIMEOUT_CYCLES, 1024: number of WAIT_ACK cycles before TimeoutErr is raised; 0 disables the timeout.
- clkA  in  1  sole clock.
- rstA  in  1  synchronous, active-high reset.
- FlagIn_clkA  in  1  one-cycle event pulse.
- AckToggle_clkA  in  1  asynchronous ack toggle from the far domain; synchronized internally.
- ClearErr_clkA  in  1  clears all sticky error flags.
- ReqToggle_clkA  out  1  registered request level; flips once per launched event.
- Busy_clkA  out  1  high in WAIT_ACK.
- Pending_clkA  out  CNT_W  queued events not yet launched.
- Done_clkA  out  1  one-cycle pulse when an ack is consumed.
- Overflow_clkA  out  1  sticky; an event was dropped at a full queue.
- TimeoutErr_clkA  out  1  sticky; the ack did not return in time.
- SpuriousAck_clkA  out  1  sticky; an ack event arrived while in IDLE.

## Operation
- States: IDLE, WAIT_ACK.
- launch = (state==IDLE) && (Pending_clkA!=0 || FlagIn_clkA).
- On launch: ReqToggle flips, state goes to WAIT_ACK, timeout counter clears.
- Pending update: Pending_next = Pending + FlagIn − launch, with the following boundary cases:
  - At MAX with FlagIn and no launch: the count holds at MAX and Overflow sets.
  - At MAX with FlagIn and launch: the count holds at MAX and there is no overflow.
- Ack detection:
  - AckSync[0..SYNC_STAGES−1] is a shift chain; AckPrev is registered from the last stage.
  - ack_evt = AckSync[last] ^ AckPrev.
- WAIT_ACK with ack_evt: return to IDLE and pulse Done for one cycle. A queued event launches no earlier than the next cycle, so IDLE lasts at least one cycle between events.
- IDLE with ack_evt: ignore it and set SpuriousAck.
- Timeout:
  - A saturating counter increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES−1, TimeoutErr sets and the counter holds.
  - The FSM keeps waiting; no retransmit, because a retransmit would desynchronize the toggle parity.
- ClearErr clears all three sticky flags. If a set condition occurs in the same cycle, set wins.
- Reset values: ReqToggle=0, Busy=0, Pending=0, Done=0, all sticky flags=0, AckSync/AckPrev=0, state IDLE.
- Reset mid-operation discards queued and in-flight events. The far-side receiver must be reset in the same window so that the toggle parity restarts at 0 on both ends.

## Timing
- Idle launch latency: a FlagIn sampled at edge k gives ReqToggle flipped and Busy=1 after edge k.
- Ack path: an AckToggle change before edge j gives ack_evt high in the cycle after edge j+SYNC_STAGES−1. It is consumed at edge j+SYNC_STAGES, where Busy falls and Done rises.
- Back-to-back throughput with a far-side delay of D cycles is one event per D+SYNC_STAGES+2 cycles minimum.
- Pending_clkA and Busy_clkA are registered with no combinational path from inputs. ReqToggle_clkA is driven directly from a flop.

## Structure
- The shared package holds the state enum (IDLE, WAIT_ACK).
- Sub-module sync_bits: a parameterized N-stage synchronizer with width and stage-count parameters and reset to 0. It is reused for AckSync.
- The top module contains the FSM, pending counter, timeout counter and sticky flags.

## Test plan
- **Single event.** After reset, pulse FlagIn once, then return the ack toggle 5 cycles later.
  - ReqToggle goes 0→1 one cycle after the pulse.
  - Done pulses 2 cycles after the ack flips.
  - Pending stays 0.
- **Burst.** Pulse FlagIn on 6 consecutive cycles while the far side acks each request after 3 cycles.
  - Pending peaks at 5.
  - ReqToggle flips exactly 6 times.
  - Done fires 6 times.
  - Overflow stays 0.
- **Overflow.** Hold the ack and issue 17 pulses with CNT_W=4.
  - Pending saturates at 15.
  - Overflow sets on the 17th pulse.
  - One event is in flight.
- **Timeout.** TIMEOUT_CYCLES=8, launch one event, no ack.
  - TimeoutErr sets 8 cycles after launch.
  - A late ack still returns the FSM to IDLE with a Done pulse.
- **Spurious ack and clear.** Toggle the ack in IDLE.
  - SpuriousAck sets 2 cycles later.
  - ClearErr clears it, except when a spurious ack arrives in the same cycle as ClearErr, in which case the flag stays set.
- **Reset mid-flight.** Assert rstA for 1 cycle while Busy=1 and Pending=3.
  - All outputs are 0 on the next cycle.
  - A new event launches with ReqToggle 0→1.

Source files
------------

// File: rtl/flag_handshake_sender_pkg.sv
// Shared types for the toggle-encoded event sender.
package flag_handshake_sender_pkg;

  // Sender FSM: either free to launch, or holding one event in flight.
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitAck = 1'b1
  } state_e;

endpackage

// File: rtl/flag_handshake_sender_sync_bits.sv
// N-stage flop synchronizer, synchronous active-high reset to 0.
module flag_handshake_sender_sync_bits #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] chain_q;
  logic [Stages-1:0][Width-1:0] chain_d;

  // Shift the asynchronous input one stage deeper every cycle.
  always_comb begin
    chain_d = {chain_q[Stages-2:0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/flag_handshake_sender.sv
// Transmit side of a toggle request/ack event crossing with a saturating event queue.
module flag_handshake_sender
  import flag_handshake_sender_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clkA,
  input  logic             rstA,
  input  logic             FlagIn_clkA,
  input  logic             AckToggle_clkA,
  input  logic             ClearErr_clkA,
  output logic             ReqToggle_clkA,
  output logic             Busy_clkA,
  output logic [CNT_W-1:0] Pending_clkA,
  output logic             Done_clkA,
  output logic             Overflow_clkA,
  output logic             TimeoutErr_clkA,
  output logic             SpuriousAck_clkA
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1 and then hold.
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0]   ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PendMax = '1;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             to_err_q, to_err_d;
  logic             sp_q, sp_d;
  logic             ack_prev_q;

  logic ack_sync;
  logic ack_evt;
  logic launch;
  logic ovf_set, to_set, sp_set;

  flag_handshake_sender_sync_bits #(
    .Width  (1),
    .Stages (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clkA),
    .rst_i (rstA),
    .d_i   (AckToggle_clkA),
    .q_o   (ack_sync)
  );

  // Any edge of the synchronized ack level is one returned acknowledge.
  assign ack_evt = ack_sync ^ ack_prev_q;

  // Launch from idle either a queued event or one arriving this cycle.
  assign launch = (state_q == StIdle) && ((pend_q != '0) || FlagIn_clkA);

  // Pending queue: add arrivals, remove launches, saturate and flag drops at full.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    unique case ({FlagIn_clkA, launch})
      2'b10: begin
        if (pend_q == PendMax) begin
          ovf_set = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  // FSM next state, request toggle, done pulse and timeout counting.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    to_cnt_d = to_cnt_q;
    done_d   = 1'b0;
    to_set   = 1'b0;
    sp_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // No request outstanding, so an ack edge here is a protocol error.
        if (ack_evt) begin
          sp_set = 1'b1;
        end
        if (launch) begin
          state_d  = StWaitAck;
          req_d    = ~req_q;
          to_cnt_d = '0;
        end
      end
      StWaitAck: begin
        if (ack_evt) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
        // Keep waiting after a timeout: resending would break toggle parity.
        if (TIMEOUT_CYCLES != 0) begin
          if (to_cnt_q == ToLast) begin
            to_set = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_comb begin
    ovf_d    = ovf_set | (ovf_q & ~ClearErr_clkA);
    to_err_d = to_set | (to_err_q & ~ClearErr_clkA);
    sp_d     = sp_set | (sp_q & ~ClearErr_clkA);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clkA) begin
    if (rstA) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      pend_q     <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      to_err_q   <= 1'b0;
      sp_q       <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      to_err_q   <= to_err_d;
      sp_q       <= sp_d;
      ack_prev_q <= ack_sync;
    end
  end

  assign ReqToggle_clkA   = req_q;
  assign Busy_clkA        = (state_q == StWaitAck);
  assign Pending_clkA     = pend_q;
  assign Done_clkA        = done_q;
  assign Overflow_clkA    = ovf_q;
  assign TimeoutErr_clkA  = to_err_q;
  assign SpuriousAck_clkA = sp_q;

endmodule

// File: tb/tb_flag_handshake_sender.sv
// Self-checking bench for flag_handshake_sender: directed steps plus a random phase
// checked every cycle against an event-level reference model.
module tb_flag_handshake_sender;

  localparam int unsigned SyncStages    = 2;
  localparam int unsigned CntW          = 4;
  localparam int unsigned TimeoutCycles = 8;
  localparam int          PendMax       = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst, flag, ack, clr;
  logic            req, busy, done, ovf, to_err, sp;
  logic [CntW-1:0] pend;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding-event flag, integer queue depth, elapsed wait time,
  // and a log of sampled ack levels (the sender sees an ack level SyncStages edges late).
  bit m_busy, m_req, m_done, m_ovf, m_to, m_sp;
  int m_pend, m_wait;
  bit ack_log[$];

  // Far-side responder: returns the request toggle resp_delay cycles after it changes.
  bit auto_ack;
  int resp_delay, resp_cnt;

  // Burst statistics.
  int flips, dones, peak;

  flag_handshake_sender #(
    .SYNC_STAGES    (SyncStages),
    .CNT_W          (CntW),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clkA             (clk),
    .rstA             (rst),
    .FlagIn_clkA      (flag),
    .AckToggle_clkA   (ack),
    .ClearErr_clkA    (clr),
    .ReqToggle_clkA   (req),
    .Busy_clkA        (busy),
    .Pending_clkA     (pend),
    .Done_clkA        (done),
    .Overflow_clkA    (ovf),
    .TimeoutErr_clkA  (to_err),
    .SpuriousAck_clkA (sp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs presented at this edge, compare, respond.
  task automatic tick();
    bit f, a, c, r, evt, launch, ovf_set, to_set, sp_set;
    f = flag; a = ack; c = clr; r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 0; m_req = 0; m_done = 0; m_ovf = 0; m_to = 0; m_sp = 0;
      m_pend = 0; m_wait = 0;
      ack_log = {};
      for (int i = 0; i <= int'(SyncStages); i++) ack_log.push_back(1'b0);
    end else begin
      evt     = ack_log[0] ^ ack_log[1];
      launch  = !m_busy && (m_pend != 0 || f);
      ovf_set = f && !launch && m_pend == PendMax;
      sp_set  = !m_busy && evt;
      to_set  = m_busy && TimeoutCycles != 0 && m_wait >= int'(TimeoutCycles) - 1;
      m_done  = m_busy && evt;
      if (!ovf_set) m_pend = m_pend + int'(f) - int'(launch);
      if (launch) begin
        m_busy = 1; m_req = !m_req; m_wait = 0;
      end else if (m_busy && evt) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_wait++;
      end
      m_ovf = ovf_set || (m_ovf && !c);
      m_to  = to_set || (m_to && !c);
      m_sp  = sp_set || (m_sp && !c);
      void'(ack_log.pop_front());
      ack_log.push_back(a);
    end
    check("m_req", 32'(req), 32'(m_req));
    check("m_busy", 32'(busy), 32'(m_busy));
    check("m_pending", 32'(pend), 32'(m_pend));
    check("m_done", 32'(done), 32'(m_done));
    check("m_overflow", 32'(ovf), 32'(m_ovf));
    check("m_timeout", 32'(to_err), 32'(m_to));
    check("m_spurious", 32'(sp), 32'(m_sp));
    if (auto_ack) begin
      if (req !== ack) begin
        if (resp_cnt <= 0) begin
          ack = ~ack;
          resp_cnt = resp_delay;
        end else begin
          resp_cnt--;
        end
      end else begin
        resp_cnt = resp_delay;
      end
    end
  endtask

  task automatic tick_stats();
    logic prev;
    prev = req;
    tick();
    if (req !== prev) flips++;
    if (done === 1'b1) dones++;
    if (int'(pend) > peak) peak = int'(pend);
  endtask

  initial begin
    rst = 1; flag = 0; ack = 0; clr = 0;
    auto_ack = 0; resp_delay = 3; resp_cnt = 3;

    // Reset state
    tick(); tick();
    check("rst_req", 32'(req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pend), 0);
    rst = 0;
    tick();

    // Single event, ack returned 5 cycles later
    flag = 1; tick(); flag = 0;
    check("single_req", 32'(req), 1);
    check("single_busy", 32'(busy), 1);
    check("single_pending", 32'(pend), 0);
    repeat (5) tick();
    ack = 1;
    tick(); tick();
    check("single_done_early", 32'(done), 0);
    tick();
    check("single_done", 32'(done), 1);
    check("single_idle", 32'(busy), 0);
    tick();
    check("single_done_pulse", 32'(done), 0);

    // Burst of 6 with far side acking after 3 cycles
    auto_ack = 1; resp_delay = 3; resp_cnt = 3;
    flips = 0; dones = 0; peak = 0;
    for (int i = 0; i < 6; i++) begin
      flag = 1;
      tick_stats();
    end
    flag = 0;
    for (int i = 0; i < 150 && (busy !== 1'b0 || pend !== '0); i++) tick_stats();
    check("burst_drained", 32'(busy), 0);
    check("burst_peak", 32'(peak), 5);
    check("burst_flips", 32'(flips), 6);
    check("burst_dones", 32'(dones), 6);
    check("burst_overflow", 32'(ovf), 0);

    // Overflow: ack held, 17 pulses
    auto_ack = 0;
    for (int i = 0; i < 17; i++) begin
      flag = 1;
      tick();
      if (i == 15) check("ovf_not_yet", 32'(ovf), 0);
    end
    flag = 0;
    check("ovf_pending", 32'(pend), 15);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_in_flight", 32'(busy), 1);
    auto_ack = 1; resp_delay = 2; resp_cnt = 2;
    for (int i = 0; i < 400 && (busy !== 1'b0 || pend !== '0); i++) tick();
    check("ovf_drained", 32'(busy), 0);
    clr = 1; tick(); clr = 0;
    check("ovf_cleared", 32'(ovf), 0);

    // Timeout with no ack, then a late ack
    auto_ack = 0;
    flag = 1; tick(); flag = 0;
    repeat (7) tick();
    check("to_early", 32'(to_err), 0);
    tick();
    check("to_set", 32'(to_err), 1);
    check("to_still_busy", 32'(busy), 1);
    ack = ~ack;
    repeat (3) tick();
    check("to_late_done", 32'(done), 1);
    check("to_late_idle", 32'(busy), 0);
    clr = 1; tick(); clr = 0;
    check("to_cleared", 32'(to_err), 0);

    // Spurious ack in idle, then clear; then clear coinciding with a spurious ack
    ack = ~ack;
    tick(); tick();
    check("sp_early", 32'(sp), 0);
    tick();
    check("sp_set", 32'(sp), 1);
    clr = 1; tick(); clr = 0;
    check("sp_cleared", 32'(sp), 0);
    ack = ~ack;
    tick(); tick();
    clr = 1; tick(); clr = 0;
    check("sp_set_wins", 32'(sp), 1);
    clr = 1; tick(); clr = 0;
    check("sp_cleared2", 32'(sp), 0);

    // Random traffic against the model
    auto_ack = 1; resp_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) resp_delay = int'($urandom_range(0, 5));
      flag = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    flag = 0; clr = 0; auto_ack = 0;

    // Reset mid-flight with Busy=1 and Pending=3
    rst = 1; ack = 0; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      flag = 1;
      tick();
    end
    flag = 0;
    check("mid_busy", 32'(busy), 1);
    check("mid_pending", 32'(pend), 3);
    rst = 1; tick(); rst = 0;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pending", 32'(pend), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_flags", {29'b0, ovf, to_err, sp}, 0);
    flag = 1; tick(); flag = 0;
    check("post_rst_req", 32'(req), 1);
    check("post_rst_busy", 32'(busy), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
